// File: rtl/sobel_stage_pkg.sv
// Shared defaults and FSM encoding for the Sobel edge stage.
// Imported by sobel_window and sobel_stage.
package sobel_stage_pkg;

   localparam int IMG_WIDTH_DEF  = 720;
   localparam int IMG_HEIGHT_DEF = 540;
   localparam int PIX_WIDTH_DEF  = 8;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/sobel_window.sv
// Two-line-plus-two-pixel shift register feeding the 3x3 Sobel window.
// Ports: clock, shift_en (consume one pixel), din (pixel in),
//        p21..p00 (registered window taps; p22 is the live head pixel).
module sobel_window
   import sobel_stage_pkg::*;
#(
   parameter int W  = IMG_WIDTH_DEF,
   parameter int PW = PIX_WIDTH_DEF
)(
   input  logic          clock,
   input  logic          shift_en,
   input  logic [PW-1:0] din,
   output logic [PW-1:0] p21,
   output logic [PW-1:0] p20,
   output logic [PW-1:0] p12,
   output logic [PW-1:0] p11,
   output logic [PW-1:0] p10,
   output logic [PW-1:0] p02,
   output logic [PW-1:0] p01,
   output logic [PW-1:0] p00
);

   localparam int N = 2*W + 2;

   // Contents are deliberately never cleared; the border rule
   // masks every output that could see stale data.
   logic [PW-1:0] r_sr [N];

   always_ff @(posedge clock) begin
      if (shift_en) begin
         r_sr[0] <= din;
         for (int i = 1; i < N; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
      end
   end

   assign p21 = r_sr[0];
   assign p20 = r_sr[1];
   assign p12 = r_sr[W-1];
   assign p11 = r_sr[W];
   assign p10 = r_sr[W+1];
   assign p02 = r_sr[2*W-1];
   assign p01 = r_sr[2*W];
   assign p00 = r_sr[2*W+1];

endmodule

// File: rtl/sobel_stage.sv
// Streaming 3x3 Sobel edge-magnitude filter between two FWFT FIFOs.
// Ports: clock, reset (sync, active-low), in_dout/in_empty/in_rd_en
//        (upstream FIFO), out_din/out_full/out_wr_en (downstream FIFO),
//        frame_done (registered pulse after the last write of a frame).
module sobel_stage
   import sobel_stage_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int PIX_WIDTH  = PIX_WIDTH_DEF
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [PIX_WIDTH-1:0] in_dout,
   input  logic                 in_empty,
   output logic                 in_rd_en,
   output logic [PIX_WIDTH-1:0] out_din,
   input  logic                 out_full,
   output logic                 out_wr_en,
   output logic                 frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int SW = PIX_WIDTH + 2;
   localparam int DW = PIX_WIDTH + 3;
   localparam int MW = PIX_WIDTH + 4;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [MW-1:0] PIX_MAX  = MW'((1 << PIX_WIDTH) - 1);

   state_t        r_state;
   logic [CW-1:0] r_in_col;
   logic [RW-1:0] r_in_row;
   logic [CW-1:0] r_out_col;
   logic [RW-1:0] r_out_row;
   logic          r_frame_done;

   logic [PIX_WIDTH-1:0] w_p22, w_p21, w_p20;
   logic [PIX_WIDTH-1:0] w_p12, w_p11, w_p10;
   logic [PIX_WIDTH-1:0] w_p02, w_p01, w_p00;

   logic [SW-1:0] w_gx_pos, w_gx_neg;
   logic [SW-1:0] w_gy_pos, w_gy_neg;
   logic [DW-1:0] w_gx, w_gy;
   logic [DW-1:0] w_gx_abs, w_gy_abs;
   logic [MW-1:0] w_mag;
   logic [PIX_WIDTH-1:0] w_clip;
   logic          w_border;
   logic          w_go;

   sobel_window #(
      .W  (IMG_WIDTH),
      .PW (PIX_WIDTH)
   ) u_window (
      .clock    (clock),
      .shift_en (in_rd_en),
      .din      (in_dout),
      .p21      (w_p21),
      .p20      (w_p20),
      .p12      (w_p12),
      .p11      (w_p11),
      .p10      (w_p10),
      .p02      (w_p02),
      .p01      (w_p01),
      .p00      (w_p00)
   );

   assign w_p22 = in_dout;

   // Centre tap is not part of the Sobel kernel.
   logic w_unused;
   assign w_unused = ^w_p11;

   assign w_gx_pos = SW'(w_p02) + SW'({w_p12, 1'b0}) + SW'(w_p22);
   assign w_gx_neg = SW'(w_p00) + SW'({w_p10, 1'b0}) + SW'(w_p20);
   assign w_gy_pos = SW'(w_p20) + SW'({w_p21, 1'b0}) + SW'(w_p22);
   assign w_gy_neg = SW'(w_p00) + SW'({w_p01, 1'b0}) + SW'(w_p02);

   assign w_gx = {1'b0, w_gx_pos} - {1'b0, w_gx_neg};
   assign w_gy = {1'b0, w_gy_pos} - {1'b0, w_gy_neg};

   assign w_gx_abs = w_gx[DW-1] ? (DW'(0) - w_gx) : w_gx;
   assign w_gy_abs = w_gy[DW-1] ? (DW'(0) - w_gy) : w_gy;

   assign w_mag  = {1'b0, w_gx_abs} + {1'b0, w_gy_abs};
   assign w_clip = (w_mag > PIX_MAX) ? '1 : w_mag[PIX_WIDTH-1:0];

   // Border masking also hides the row wrap inside the window.
   assign w_border = (r_out_row == '0) || (r_out_row == ROW_LAST) ||
                     (r_out_col == '0) || (r_out_col == COL_LAST);

   assign w_go = !in_empty && !out_full;

   always_comb begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      if (reset) begin
         unique case (r_state)
            FILL:  in_rd_en = !in_empty;
            RUN: begin
               in_rd_en  = w_go;
               out_wr_en = w_go;
            end
            FLUSH: out_wr_en = !out_full;
            default: ;
         endcase
      end
   end

   assign out_din    = (reset && !w_border) ? w_clip : '0;
   assign frame_done = r_frame_done;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= FILL;
         r_in_col     <= '0;
         r_in_row     <= '0;
         r_out_col    <= '0;
         r_out_row    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;

         if (in_rd_en) begin
            if (r_in_col == COL_LAST) begin
               r_in_col <= '0;
               r_in_row <= (r_in_row == ROW_LAST) ? '0 : r_in_row + RW'(1);
            end else begin
               r_in_col <= r_in_col + CW'(1);
            end
         end

         if (out_wr_en) begin
            if (r_out_col == COL_LAST) begin
               r_out_col <= '0;
               r_out_row <= (r_out_row == ROW_LAST) ? '0 : r_out_row + RW'(1);
            end else begin
               r_out_col <= r_out_col + CW'(1);
            end
         end

         unique case (r_state)
            FILL: begin
               // Pixel index W is (row 1, col 0): W+1 pixels now in.
               if (in_rd_en && r_in_row == RW'(1) && r_in_col == '0)
                  r_state <= RUN;
            end
            RUN: begin
               if (in_rd_en && r_in_row == ROW_LAST && r_in_col == COL_LAST)
                  r_state <= FLUSH;
            end
            FLUSH: begin
               if (out_wr_en && r_out_row == ROW_LAST &&
                   r_out_col == COL_LAST) begin
                  r_state      <= FILL;
                  r_frame_done <= 1'b1;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

endmodule
